// File: rtl/boreal_cursor_accum.sv
// Sub-pixel cursor accumulator and click shaper feeding the HID mouse core.
// Optional velocity deadzone: define BOREAL_ACCUM_DEADZONE_EN.

module boreal_cursor_axis #(
  parameter int VEL_W    = 16,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 24,
  parameter int DEADZONE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [VEL_W-1:0] vel,
  input  logic                    vel_valid,
  input  logic [1:0]              tier,
  input  logic                    report_tick,
  output logic signed [7:0]       delta,
  output logic                    sat,
  output logic signed [ACC_W-1:0] acc
);
`ifdef BOREAL_ACCUM_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif
  localparam logic signed [ACC_W-1:0] DZ      = ACC_W'(DEADZONE);
  localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN   = -Q_MAX;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [7:0]       delta_q, delta_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] v_ext, acc_upd, q, c;
  logic signed [ACC_W:0]   sum;

  always_comb begin
    v_ext = {{(ACC_W-VEL_W){vel[VEL_W-1]}}, vel};
    if (tier == 2'd1) v_ext = v_ext >>> 1;
    if (DZ_EN && (v_ext > -DZ) && (v_ext < DZ)) v_ext = '0;

    // One guard bit so the clamp sees the true sum before it wraps.
    sum   = {acc_q[ACC_W-1], acc_q} + (vel_valid ? {v_ext[ACC_W-1], v_ext} : '0);
    sat_d = 1'b0;
    if (sum > SUM_MAX) begin
      acc_upd = SUM_MAX[ACC_W-1:0];
      sat_d   = 1'b1;
    end else if (sum < SUM_MIN) begin
      acc_upd = SUM_MIN[ACC_W-1:0];
      sat_d   = 1'b1;
    end else begin
      acc_upd = sum[ACC_W-1:0];
    end

    q = acc_upd >>> FRAC;
    if (q > Q_MAX)      c = Q_MAX;
    else if (q < Q_MIN) c = Q_MIN;
    else                c = q;

    acc_d   = acc_upd;
    delta_d = delta_q;
    if (report_tick) begin
      delta_d = c[7:0];
      acc_d   = acc_upd - (c <<< FRAC);
    end
    if (tier[1]) begin
      acc_d   = '0;
      delta_d = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      delta_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      delta_q <= delta_d;
      sat_q   <= sat_d;
    end
  end

  assign delta = delta_q;
  assign sat   = sat_q;
  assign acc   = acc_q;
endmodule

module boreal_click_fsm #(
  parameter int CLICK_TICKS = 2,
  parameter int GAP_TICKS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       tick,
  input  logic       freeze,
  output logic       button,
  output logic [1:0] state
);
  localparam int CMAX  = (CLICK_TICKS > GAP_TICKS) ? CLICK_TICKS : GAP_TICKS;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] CNT_CLICK = CNT_W'(CLICK_TICKS);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_HOLD = 2'd1, C_GAP = 2'd2} click_state_e;

  click_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             btn_q, btn_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    btn_d   = btn_q;
    case (state_q)
      C_IDLE: begin
        if (req) begin
          state_d = C_HOLD;
          btn_d   = 1'b1;
          cnt_d   = CNT_CLICK;
        end
      end
      C_HOLD: begin
        if (req) pend_d = 1'b1;
        if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            btn_d = 1'b0;
            if (GAP_TICKS != 0) begin
              state_d = C_GAP;
              cnt_d   = CNT_GAP;
            end else if (pend_d) begin
              state_d = C_HOLD;
              btn_d   = 1'b1;
              cnt_d   = CNT_CLICK;
              pend_d  = 1'b0;
            end else begin
              state_d = C_IDLE;
            end
          end
        end
      end
      C_GAP: begin
        if (req) pend_d = 1'b1;
        if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // A latched request skips IDLE and starts the next pulse at once.
            if (pend_d) begin
              state_d = C_HOLD;
              btn_d   = 1'b1;
              cnt_d   = CNT_CLICK;
              pend_d  = 1'b0;
            end else begin
              state_d = C_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = C_IDLE;
        btn_d   = 1'b0;
      end
    endcase
    if (freeze) begin
      state_d = C_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      btn_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      btn_q   <= btn_d;
    end
  end

  assign button = btn_q;
  assign state  = state_q;
endmodule

module boreal_cursor_accum #(
  parameter int VEL_W       = 16,
  parameter int FRAC        = 8,
  parameter int ACC_W       = 24,
  parameter int CLICK_TICKS = 2,
  parameter int GAP_TICKS   = 1,
  parameter int DEADZONE    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [VEL_W-1:0] vel_x,
  input  logic signed [VEL_W-1:0] vel_y,
  input  logic                    vel_valid,
  input  logic                    click_l_req,
  input  logic                    click_r_req,
  input  logic [1:0]              tier,
  input  logic                    report_tick,
  output logic signed [7:0]       dx,
  output logic signed [7:0]       dy,
  output logic                    left_click,
  output logic                    right_click,
  output logic                    sat_flag,
  output logic signed [ACC_W-1:0] dbg_acc_x,
  output logic signed [ACC_W-1:0] dbg_acc_y,
  output logic [1:0]              dbg_state_l,
  output logic [1:0]              dbg_state_r
);
  logic sat_x, sat_y;

  boreal_cursor_axis #(.VEL_W(VEL_W), .FRAC(FRAC), .ACC_W(ACC_W), .DEADZONE(DEADZONE)) u_axis_x (
    .clk(clk), .rst(rst), .vel(vel_x), .vel_valid(vel_valid), .tier(tier),
    .report_tick(report_tick), .delta(dx), .sat(sat_x), .acc(dbg_acc_x)
  );

  boreal_cursor_axis #(.VEL_W(VEL_W), .FRAC(FRAC), .ACC_W(ACC_W), .DEADZONE(DEADZONE)) u_axis_y (
    .clk(clk), .rst(rst), .vel(vel_y), .vel_valid(vel_valid), .tier(tier),
    .report_tick(report_tick), .delta(dy), .sat(sat_y), .acc(dbg_acc_y)
  );

  boreal_click_fsm #(.CLICK_TICKS(CLICK_TICKS), .GAP_TICKS(GAP_TICKS)) u_click_l (
    .clk(clk), .rst(rst), .req(click_l_req), .tick(report_tick), .freeze(tier[1]),
    .button(left_click), .state(dbg_state_l)
  );

  boreal_click_fsm #(.CLICK_TICKS(CLICK_TICKS), .GAP_TICKS(GAP_TICKS)) u_click_r (
    .clk(clk), .rst(rst), .req(click_r_req), .tick(report_tick), .freeze(tier[1]),
    .button(right_click), .state(dbg_state_r)
  );

  assign sat_flag = sat_x | sat_y;
endmodule

// File: tb/tb_boreal_cursor_accum.sv
// Directed bench for boreal_cursor_accum: integer reference model, scoreboard queue
// of per-tick expectations, immediate-assertion checks and a one-line summary.

module tb_boreal_cursor_accum;
  localparam int ACC_LIM = 8388607;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vel_x, vel_y;
  logic        vel_valid, click_l_req, click_r_req, report_tick;
  logic [1:0]  tier;
  logic [7:0]  dx, dy;
  logic        left_click, right_click, sat_flag;
  logic [23:0] dbg_acc_x, dbg_acc_y;
  logic [1:0]  dbg_state_l, dbg_state_r;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int sat_pulses;
  int mx = 0;
  int my = 0;
  logic [17:0] exp_q[$];

  boreal_cursor_accum #(
    .VEL_W(16), .FRAC(8), .ACC_W(24), .CLICK_TICKS(2), .GAP_TICKS(1), .DEADZONE(16)
  ) dut (
    .clk(clk), .rst(rst), .vel_x(vel_x), .vel_y(vel_y), .vel_valid(vel_valid),
    .click_l_req(click_l_req), .click_r_req(click_r_req), .tier(tier),
    .report_tick(report_tick), .dx(dx), .dy(dy), .left_click(left_click),
    .right_click(right_click), .sat_flag(sat_flag), .dbg_acc_x(dbg_acc_x),
    .dbg_acc_y(dbg_acc_y), .dbg_state_l(dbg_state_l), .dbg_state_r(dbg_state_r)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  function automatic int scale(input logic [15:0] v, input logic [1:0] t);
    int s;
    s = int'(signed'(v));
    if (t == 2'd1) s = s >>> 1;
`ifdef BOREAL_ACCUM_DEADZONE_EN
    if (s > -16 && s < 16) s = 0;
`endif
    return s;
  endfunction

  function automatic int add_sat(input int a, input int v, output bit clamped);
    int s;
    s = a + v;
    clamped = 1'b0;
    if (s > ACC_LIM) begin
      s = ACC_LIM;
      clamped = 1'b1;
    end else if (s < -ACC_LIM) begin
      s = -ACC_LIM;
      clamped = 1'b1;
    end
    return s;
  endfunction

  function automatic int take(input int a);
    int q;
    q = a >>> 8;
    if (q > 127) q = 127;
    else if (q < -127) q = -127;
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_acc_x"}, {8'h0, dbg_acc_x}, {8'h0, mx[23:0]});
    check({tag, "_acc_y"}, {8'h0, dbg_acc_y}, {8'h0, my[23:0]});
  endtask

  // driver tasks (inputs change on the falling edge, outputs checked on the next one)
  task automatic strobe(input logic [15:0] vx, input logic [15:0] vy, input int n);
    bit clx, cly;
    for (int i = 0; i < n; i++) begin
      clx = 1'b0;
      cly = 1'b0;
      if (tier[1]) begin
        mx = 0;
        my = 0;
      end else begin
        mx = add_sat(mx, scale(vx, tier), clx);
        my = add_sat(my, scale(vy, tier), cly);
      end
      vel_x = vx;
      vel_y = vy;
      vel_valid = 1'b1;
      @(negedge clk);
      vel_valid = 1'b0;
      check("strobe_sat", {31'h0, sat_flag}, {31'h0, clx | cly});
      check_acc("strobe");
      sat_pulses += int'(sat_flag);
    end
  endtask

  task automatic tick(input bit exp_l, input bit exp_r, input bit with_vel = 1'b0,
                      input logic [15:0] vx = 16'h0, input logic [15:0] vy = 16'h0);
    int cx, cy;
    bit clx, cly;
    logic [17:0] e;
    cx = 0;
    cy = 0;
    clx = 1'b0;
    cly = 1'b0;
    if (tier[1]) begin
      mx = 0;
      my = 0;
    end else begin
      if (with_vel) begin
        mx = add_sat(mx, scale(vx, tier), clx);
        my = add_sat(my, scale(vy, tier), cly);
      end
      cx = take(mx);
      cy = take(my);
      mx = mx - cx * 256;
      my = my - cy * 256;
    end
    exp_q.push_back({cx[7:0], cy[7:0], exp_l, exp_r});
    vel_x = vx;
    vel_y = vy;
    vel_valid = with_vel;
    report_tick = 1'b1;
    @(negedge clk);
    vel_valid = 1'b0;
    report_tick = 1'b0;
    e = exp_q.pop_front();
    check("tick_dx", {24'h0, dx}, {24'h0, e[17:10]});
    check("tick_dy", {24'h0, dy}, {24'h0, e[9:2]});
    check("tick_left", {31'h0, left_click}, {31'h0, e[1]});
    check("tick_right", {31'h0, right_click}, {31'h0, e[0]});
    check("tick_sat", {31'h0, sat_flag}, {31'h0, clx | cly});
    check_acc("tick");
    @(negedge clk);
  endtask

  task automatic click(input bit l, input bit r, input bit exp_l, input bit exp_r);
    click_l_req = l;
    click_r_req = r;
    @(negedge clk);
    click_l_req = 1'b0;
    click_r_req = 1'b0;
    check("click_left", {31'h0, left_click}, {31'h0, exp_l});
    check("click_right", {31'h0, right_click}, {31'h0, exp_r});
  endtask

  initial begin
    rst = 1'b1;
    tier = 2'd0;
    vel_x = '0;
    vel_y = '0;
    vel_valid = 1'b0;
    click_l_req = 1'b0;
    click_r_req = 1'b0;
    report_tick = 1'b0;
    sat_pulses = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_dx", {24'h0, dx}, 32'h0);
    check("rst_dy", {24'h0, dy}, 32'h0);
    check("rst_left", {31'h0, left_click}, 32'h0);
    check("rst_right", {31'h0, right_click}, 32'h0);
    check("rst_sat", {31'h0, sat_flag}, 32'h0);
    check("rst_state_l", {30'h0, dbg_state_l}, 32'h0);
    check_acc("rst");

    // fractional carry: 6 x 0.25 -> 1 pixel with 0.5 left, then 2 more -> exactly 1
    strobe(16'h0040, 16'h0000, 6);
    tick(1'b0, 1'b0);
    check("frac_dx1", {24'h0, dx}, 32'h1);
    check("frac_rem", {8'h0, dbg_acc_x}, 32'h80);
    strobe(16'h0040, 16'h0000, 2);
    tick(1'b0, 1'b0);
    check("frac_dx2", {24'h0, dx}, 32'h1);
    check("frac_zero", {8'h0, dbg_acc_x}, 32'h0);

    // delta clamp with remainder carried
    strobe(16'h7FFF, 16'h8000, 2);
    tick(1'b0, 1'b0);
    check("clamp_dx", {24'h0, dx}, 32'h7F);
    check("clamp_dy", {24'h0, dy}, 32'h81);
    check("clamp_rem", {8'h0, dbg_acc_x}, 32'h80FE);

    // accumulator saturation pulses sat_flag once
    sat_pulses = 0;
    strobe(16'h7FFF, 16'h0000, 256);
    check("sat_once", sat_pulses, 32'd1);
    @(negedge clk);
    check("sat_idle", {31'h0, sat_flag}, 32'h0);
    tick(1'b0, 1'b0);

    // tier 2 freeze while a click is held
    click(1'b1, 1'b0, 1'b1, 1'b0);
    tier = 2'd2;
    click_l_req = 1'b1;
    vel_x = 16'h0100;
    vel_valid = 1'b1;
    @(negedge clk);
    click_l_req = 1'b0;
    vel_valid = 1'b0;
    mx = 0;
    my = 0;
    check("frz_left", {31'h0, left_click}, 32'h0);
    check("frz_dx", {24'h0, dx}, 32'h0);
    check("frz_dy", {24'h0, dy}, 32'h0);
    check("frz_state_l", {30'h0, dbg_state_l}, 32'h0);
    check_acc("frz");
    tick(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100);
    tier = 2'd0;
    @(negedge clk);
    check("frz_resume_left", {31'h0, left_click}, 32'h0);

    // tier 1 halves velocity (arithmetic shift)
    tier = 2'd1;
    strobe(16'h0400, 16'hFFFD, 1);
    tick(1'b0, 1'b0);
    check("t1_dx", {24'h0, dx}, 32'h2);
    check("t1_dy", {24'h0, dy}, 32'hFF);
    tier = 2'd0;

    // click shaping: 2 ticks high, 1 low, pending pulse, third request dropped
    click(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    click(1'b1, 1'b0, 1'b1, 1'b0);
    click(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("clk_l_idle", {30'h0, dbg_state_l}, 32'h0);
    click(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("clk_r_idle", {30'h0, dbg_state_r}, 32'h0);

    // sample and tick in the same cycle, starting from a cleared accumulator
    tier = 2'd2;
    @(negedge clk);
    mx = 0;
    my = 0;
    tier = 2'd0;
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000);
    check("simul_dx", {24'h0, dx}, 32'h1);

    // small sample (dropped only when the deadzone is built in)
    strobe(16'h000F, 16'h0000, 1);
    tick(1'b0, 1'b0);

    // asynchronous reset mid-HOLD with a nonzero accumulator
    strobe(16'h0180, 16'h0000, 1);
    tick(1'b0, 1'b0);
    check("pre_rst_dx", {24'h0, dx}, 32'h1);
    strobe(16'h0200, 16'h0000, 1);
    click(1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    mx = 0;
    my = 0;
    check("arst_dx", {24'h0, dx}, 32'h0);
    check("arst_left", {31'h0, left_click}, 32'h0);
    check("arst_state_l", {30'h0, dbg_state_l}, 32'h0);
    check_acc("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tick(1'b0, 1'b0);
    check("post_rst_dx", {24'h0, dx}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
